os_acc_drain: RTL and testbench
===============================

// Module: os_acc_drain
// PURPOSE
//  Readout end of the output-stationary array: snapshots all N x N PE accumulators
//  when a matrix multiply completes, rescales/saturates each to OUT_WIDTH, and streams
//  the result one row per beat over a valid/ready interface to the downstream FFN stage.
//  Sits between the array's acc outputs and the activation/writeback path.
// PARAMETERS
//  N          4   array dimension (N x N PEs); N >= 1
//  ACC_WIDTH  64  width of each PE accumulator (signed)
//  OUT_WIDTH  16  width of each output element (signed); OUT_WIDTH <= ACC_WIDTH
//  SHIFT      0   arithmetic right shift applied before saturation; 0 <= SHIFT < ACC_WIDTH
// PORTS
//  clk          in   1                 clock, rising edge
//  rstn         in   1                 reset, asynchronous, active-low
//  start_i      in   1                 pulse: accumulators valid, begin drain
//  acc_i        in   N*N*ACC_WIDTH     PE (r,c) acc at bits [(r*N+c)*ACC_WIDTH +: ACC_WIDTH]
//  busy_o       out  1                 high while a drain is in progress
//  out_valid_o  out  1                 out_data_o holds a valid row
//  out_ready_i  in   1                 downstream accepts row
//  out_data_o   out  N*OUT_WIDTH       column c at bits [c*OUT_WIDTH +: OUT_WIDTH]
//  out_row_o    out  max(1,$clog2(N))  row index of current beat
//  out_last_o   out  1                 current beat is row N-1
//  done_o       out  1                 one-cycle pulse after final row transferred
// BEHAVIOUR
//  - Reset: state IDLE, row counter 0, snapshot buffer 0; busy_o, out_valid_o,
//    out_last_o, done_o = 0; out_data_o = 0; out_row_o = 0. Async assert, sync use.
//  - Reset mid-drain aborts: no further beats, no done_o.
//  - FSM IDLE -> DRAIN on start_i=1 (sampled at edge k); DRAIN -> IDLE on the transfer
//    (out_valid_o & out_ready_i) of row N-1. Two states only.
//  - Capture: at edge k all N*N elements converted and stored; acc_i ignored afterwards.
//  - Conversion per element: t = acc >>> SHIFT (floor, sign-preserving); result =
//    2^(OUT_WIDTH-1)-1 if t above, -2^(OUT_WIDTH-1) if t below, else t[OUT_WIDTH-1:0].
//  - Latency: out_valid_o=1, busy_o=1, out_row_o=0 in the cycle after edge k.
//  - Handshake: row advances only on valid&ready; out_data_o/out_row_o/out_last_o
//    stable while valid & !ready; ready may be high before valid; one row per cycle max.
//  - out_last_o = out_valid_o & (out_row_o == N-1); N=1 gives single beat with last=1.
//  - done_o: registered, high exactly the cycle after last-row transfer (state IDLE,
//    busy_o=0, out_valid_o=0).
//  - start_i while busy_o=1 ignored (no re-snapshot, counter unaffected).
//  - start_i in the done_o cycle is accepted: back-to-back drains, one idle cycle gap.
// TESTING
//  1 Reset: rstn low mid-cycle -> all outputs 0 immediately; after release busy_o=0.
//  2 N=2,SHIFT=0,OUT=16, acc={1,-2,300,-4}, start, ready=1 -> beat0 {1,-2} row0,
//    beat1 {300,-4} row1 last=1, done_o next cycle; busy_o high exactly 2 cycles.
//  3 Saturation/shift: SHIFT=2, acc=40000 -> 10000; acc=-5 -> -2; acc=2^40 -> 32767;
//    acc=-2^40 -> -32768.
//  4 Backpressure: ready low 3 cycles on row0 -> data/row stable, no advance; ready
//    toggling 1/0 -> each row emitted exactly once, in order.
//  5 Start while busy with changed acc_i -> ignored, original snapshot drained;
//    start in done_o cycle -> second drain begins next cycle with new values.
//  6 rstn asserted after row0 transferred -> outputs 0, no done_o; fresh start after
//    release drains from row0.

Source files
------------

// File: rtl/os_acc_drain.sv
// os_acc_drain
// Readout stage of the output-stationary array. When a matrix multiply completes
// (start_i) every PE accumulator is rescaled and saturated to OUT_WIDTH and
// latched into a row-organised snapshot buffer. The snapshot is then streamed
// one row per beat over a valid/ready interface. A one-cycle done_o pulse
// follows the final row transfer.

module os_acc_drain #(
  parameter int N         = 4,
  parameter int ACC_WIDTH = 64,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [N*N*ACC_WIDTH-1:0]     acc_i,
  output logic                         busy_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [N*OUT_WIDTH-1:0]       out_data_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_row_o,
  output logic                         out_last_o,
  output logic                         done_o
);

  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = N * OUT_WIDTH;
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               state_r;
  logic [RW-1:0]        row_r;
  logic [ROW_W-1:0]     snap_r [N];
  logic [ROW_W-1:0]     conv_s [N];
  logic                 xfer_s;
  logic [RW-1:0]        row_nxt_s;

  // Arithmetic shift (floor) followed by saturation to the signed OUT_WIDTH range.
  // The limits are built in ACC_WIDTH so the comparison is done at full precision.
  function automatic logic [OUT_WIDTH-1:0] sat_conv(input logic [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] t;
    logic signed [ACC_WIDTH-1:0] hi;
    logic signed [ACC_WIDTH-1:0] lo;
    logic [OUT_WIDTH-1:0]        res;
    t  = $signed(acc) >>> SHIFT;
    hi = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      hi[i] = (i < OUT_WIDTH - 1) ? 1'b1 : 1'b0;
    end
    lo = ~hi;
    if (t > hi) begin
      res = hi[OUT_WIDTH-1:0];
    end else if (t < lo) begin
      res = lo[OUT_WIDTH-1:0];
    end else begin
      res = t[OUT_WIDTH-1:0];
    end
    return res;
  endfunction

  assign xfer_s    = out_valid_o & out_ready_i;
  assign row_nxt_s = row_r + RW'(1);

  // Convert the live accumulator bus into packed output rows, ready for capture.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      conv_s[r] = '0;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        conv_s[r][c*OUT_WIDTH +: OUT_WIDTH] = sat_conv(acc_i[(r*N+c)*ACC_WIDTH +: ACC_WIDTH]);
      end
    end
  end

  // Drain FSM: snapshot on start, stream rows on handshake, pulse done after the last row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      row_r       <= '0;
      for (int r = 0; r < N; r++) begin
        snap_r[r] <= '0;
      end
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_row_o   <= '0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r     <= DRAIN;
            row_r       <= '0;
            for (int r = 0; r < N; r++) begin
              snap_r[r] <= conv_s[r];
            end
            busy_o      <= 1'b1;
            out_valid_o <= 1'b1;
            out_data_o  <= conv_s[0];
            out_row_o   <= '0;
            out_last_o  <= (N == 1);
          end
        end
        DRAIN: begin
          // start_i is deliberately not looked at here: the snapshot stays frozen.
          if (xfer_s) begin
            if (row_r == LAST_ROW) begin
              state_r     <= IDLE;
              row_r       <= '0;
              busy_o      <= 1'b0;
              out_valid_o <= 1'b0;
              out_data_o  <= '0;
              out_row_o   <= '0;
              out_last_o  <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              row_r       <= row_nxt_s;
              out_data_o  <= snap_r[row_nxt_s];
              out_row_o   <= row_nxt_s;
              out_last_o  <= (row_nxt_s == LAST_ROW);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          row_r       <= '0;
          busy_o      <= 1'b0;
          out_valid_o <= 1'b0;
          out_data_o  <= '0;
          out_row_o   <= '0;
          out_last_o  <= 1'b0;
          done_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_os_acc_drain.sv
// tb_os_acc_drain
// Two 2x2 instances: dut_a (SHIFT=0) for protocol/ordering scenarios and
// dut_b (SHIFT=2) for shift and saturation. Expected beats are queued by the
// stimulus and popped by per-instance monitors on each accepted beat.

module tb_os_acc_drain;

  typedef struct packed {
    logic [31:0] data;
    logic        row;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         start_a, ready_a, busy_a, valid_a, last_a, done_a, row_a;
  logic [255:0] acc_a;
  logic [31:0]  data_a;
  logic         start_b, ready_b, busy_b, valid_b, last_b, done_b, row_b;
  logic [255:0] acc_b;
  logic [31:0]  data_b;

  os_acc_drain #(.N(2), .ACC_WIDTH(64), .OUT_WIDTH(16), .SHIFT(0)) dut_a (
    .clk(clk), .rstn(rstn), .start_i(start_a), .acc_i(acc_a), .busy_o(busy_a),
    .out_valid_o(valid_a), .out_ready_i(ready_a), .out_data_o(data_a),
    .out_row_o(row_a), .out_last_o(last_a), .done_o(done_a)
  );

  os_acc_drain #(.N(2), .ACC_WIDTH(64), .OUT_WIDTH(16), .SHIFT(2)) dut_b (
    .clk(clk), .rstn(rstn), .start_i(start_b), .acc_i(acc_b), .busy_o(busy_b),
    .out_valid_o(valid_b), .out_ready_i(ready_b), .out_data_o(data_b),
    .out_row_o(row_b), .out_last_o(last_b), .done_o(done_b)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    done_cnt_a = 0;
  int    done_cnt_b = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;

  function automatic logic [255:0] pack4(input longint e0, input longint e1,
                                         input longint e2, input longint e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic beat_t mk(input logic [31:0] d, input logic r, input logic l);
    beat_t b;
    b.data = d;
    b.row  = r;
    b.last = l;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_a) break;
    end
    chk("a_idle_timeout", 64'(busy_a), 64'd0);
  endtask

  task automatic wait_idle_b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_b) break;
    end
    chk("b_idle_timeout", 64'(busy_b), 64'd0);
  endtask

  // Monitor for dut_a: each accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rstn) begin
      if (done_a) done_cnt_a++;
      if (valid_a && ready_a) begin
        if (qa.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL a_extra_beat: got data %h row %0d, expected no beat", data_a, row_a);
        end else begin
          ea = qa.pop_front();
          chk("a_data", 64'(data_a), 64'(ea.data));
          chk("a_row",  64'(row_a),  64'(ea.row));
          chk("a_last", 64'(last_a), 64'(ea.last));
        end
      end
    end
  end

  // Monitor for dut_b: same scoreboard check for the shifted instance.
  always @(negedge clk) begin
    if (rstn) begin
      if (done_b) done_cnt_b++;
      if (valid_b && ready_b) begin
        if (qb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL b_extra_beat: got data %h row %0d, expected no beat", data_b, row_b);
        end else begin
          eb = qb.pop_front();
          chk("b_data", 64'(data_b), 64'(eb.data));
          chk("b_row",  64'(row_b),  64'(eb.row));
          chk("b_last", 64'(last_b), 64'(eb.last));
        end
      end
    end
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [3:0] busy_pat;
    logic [3:0] done_pat;
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    acc_a = '0; acc_b = '0;

    // Reset state
    @(negedge clk);
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_data",  64'(data_a),  64'd0);
    chk("rst_row",   64'(row_a),   64'd0);
    chk("rst_last",  64'(last_a),  64'd0);
    chk("rst_done",  64'(done_a),  64'd0);
    #2 rstn = 1'b1;
    tick;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy_a), 64'd0);

    // Basic drain, ready held high
    acc_a = pack4(1, -2, 300, -4);
    ready_a = 1'b1;
    qa.push_back(mk(32'hFFFE_0001, 1'b0, 1'b0));
    qa.push_back(mk(32'hFFFC_012C, 1'b1, 1'b1));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    busy_pat = 4'b0000;
    done_pat = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      busy_pat[i] = busy_a;
      done_pat[i] = done_a;
    end
    chk("t2_busy_pattern", 64'(busy_pat), 64'h3);
    chk("t2_done_pattern", 64'(done_pat), 64'h4);
    chk("t2_queue_empty",  64'(qa.size()), 64'd0);
    chk("t2_done_count",   64'(done_cnt_a), 64'd1);

    // Shift by 2 with saturation
    acc_b = pack4(40000, -5, 64'sh100_0000_0000, -64'sh100_0000_0000);
    ready_b = 1'b1;
    qb.push_back(mk(32'hFFFE_2710, 1'b0, 1'b0));
    qb.push_back(mk(32'h8000_7FFF, 1'b1, 1'b1));
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    wait_idle_b;
    @(negedge clk);
    chk("t3_queue_empty", 64'(qb.size()), 64'd0);
    chk("t3_done_count",  64'(done_cnt_b), 64'd1);

    // Backpressure: ready low for three cycles, then toggling
    acc_a = pack4(10, 20, 30, 40);
    ready_a = 1'b0;
    qa.push_back(mk(32'h0014_000A, 1'b0, 1'b0));
    qa.push_back(mk(32'h0028_001E, 1'b1, 1'b1));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(valid_a), 64'd1);
      chk("t4_hold_data",  64'(data_a),  64'h0014_000A);
      chk("t4_hold_row",   64'(row_a),   64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      ready_a = ((i % 2) == 0);
    end
    wait_idle_a;
    @(negedge clk);
    chk("t4_queue_empty", 64'(qa.size()), 64'd0);
    chk("t4_done_count",  64'(done_cnt_a), 64'd2);

    // Start while busy is ignored; start in done cycle chains a second drain
    acc_a = pack4(1, 2, 3, 4);
    ready_a = 1'b0;
    qa.push_back(mk(32'h0002_0001, 1'b0, 1'b0));
    qa.push_back(mk(32'h0004_0003, 1'b1, 1'b1));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    acc_a = pack4(100, 200, 300, 400);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    @(negedge clk);
    chk("t5_ignored_data", 64'(data_a), 64'h0002_0001);
    chk("t5_ignored_row",  64'(row_a),  64'd0);
    chk("t5_ignored_busy", 64'(busy_a), 64'd1);
    tick;
    ready_a = 1'b1;
    tick;
    tick;
    acc_a = pack4(-1, -300, 32767, 5);
    qa.push_back(mk(32'hFED4_FFFF, 1'b0, 1'b0));
    qa.push_back(mk(32'h0005_7FFF, 1'b1, 1'b1));
    start_a = 1'b1;
    @(negedge clk);
    chk("t5_done_cycle_done", 64'(done_a), 64'd1);
    chk("t5_done_cycle_busy", 64'(busy_a), 64'd0);
    tick;
    start_a = 1'b0;
    @(negedge clk);
    chk("t5_second_busy",  64'(busy_a),  64'd1);
    chk("t5_second_valid", 64'(valid_a), 64'd1);
    wait_idle_a;
    @(negedge clk);
    chk("t5_queue_empty", 64'(qa.size()), 64'd0);
    chk("t5_done_count",  64'(done_cnt_a), 64'd4);

    // Reset after row 0 aborts the drain; fresh drain afterwards
    acc_a = pack4(7, 8, 9, 10);
    ready_a = 1'b1;
    qa.push_back(mk(32'h0008_0007, 1'b0, 1'b0));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    rstn = 1'b0;
    #1;
    chk("t6_rst_busy",  64'(busy_a),  64'd0);
    chk("t6_rst_valid", 64'(valid_a), 64'd0);
    chk("t6_rst_data",  64'(data_a),  64'd0);
    chk("t6_rst_row",   64'(row_a),   64'd0);
    chk("t6_rst_last",  64'(last_a),  64'd0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("t6_no_done",     64'(done_cnt_a), 64'd4);
    chk("t6_queue_empty", 64'(qa.size()), 64'd0);
    acc_a = pack4(11, 12, 13, 14);
    qa.push_back(mk(32'h000C_000B, 1'b0, 1'b0));
    qa.push_back(mk(32'h000E_000D, 1'b1, 1'b1));
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    @(negedge clk);
    chk("t6_fresh_row", 64'(row_a), 64'd0);
    wait_idle_a;
    @(negedge clk);
    chk("t6_fresh_queue_empty", 64'(qa.size()), 64'd0);
    chk("t6_fresh_done_count",  64'(done_cnt_a), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
